// File: rtl/h3_table_access_stage.sv
// Lookup/insert/delete stage behind the H3 hash: one request at a time against a
// single-port bucket memory. Optional hit/miss/collision counters under H3_TABLE_STATS_EN.
module h3_table_access_stage #(
    parameter int KEY_WIDTH      = 32,
    parameter int HASH_ADR_WIDTH = 5,
    parameter int VALUE_WIDTH    = 32,
    parameter int ENTRY_WIDTH    = 1 + KEY_WIDTH + VALUE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [KEY_WIDTH-1:0]      req_key,
    input  logic [HASH_ADR_WIDTH-1:0] req_hash_adr,
    input  logic [VALUE_WIDTH-1:0]    req_value,
    output logic [HASH_ADR_WIDTH-1:0] mem_adr,
    output logic                      mem_re,
    output logic                      mem_we,
    output logic [ENTRY_WIDTH-1:0]    mem_wdata,
    input  logic [ENTRY_WIDTH-1:0]    mem_rdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_status,
    output logic [VALUE_WIDTH-1:0]    rsp_value,
    output logic [2:0]                dbg_state
`ifdef H3_TABLE_STATS_EN
    ,
    output logic [15:0]               stat_hits,
    output logic [15:0]               stat_misses,
    output logic [15:0]               stat_collisions
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CMP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    localparam logic [1:0] OP_LOOKUP  = 2'b00;
    localparam logic [1:0] OP_INSERT  = 2'b01;
    localparam logic [1:0] OP_DELETE  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NFOUND  = 2'b01;
    localparam logic [1:0] ST_COLL    = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    logic [2:0]                r_state;
    logic [1:0]                r_op;
    logic [KEY_WIDTH-1:0]      r_key;
    logic [HASH_ADR_WIDTH-1:0] r_adr;
    logic [VALUE_WIDTH-1:0]    r_value;
    logic [1:0]                r_status;
    logic [VALUE_WIDTH-1:0]    r_rsp_value;

    logic                      w_accept;
    logic                      w_stored_valid;
    logic [KEY_WIDTH-1:0]      w_stored_key;
    logic [VALUE_WIDTH-1:0]    w_stored_value;
    logic                      w_hit;
    logic                      w_rsp_done;

    assign w_accept       = req_valid && (r_state == S_IDLE);
    assign w_stored_valid = mem_rdata[ENTRY_WIDTH-1];
    assign w_stored_key   = mem_rdata[ENTRY_WIDTH-2 -: KEY_WIDTH];
    assign w_stored_value = mem_rdata[VALUE_WIDTH-1:0];
    assign w_hit          = w_stored_valid && (w_stored_key == r_key);
    assign w_rsp_done     = (r_state == S_RSP) && rsp_ready;

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RSP);
    assign rsp_status = r_status;
    assign rsp_value  = r_rsp_value;
    assign dbg_state  = r_state;
    assign mem_adr    = r_adr;
    assign mem_re     = (r_state == S_RD);
    assign mem_we     = (r_state == S_WR);
    // A delete is the only other writing op, and it clears the whole word.
    assign mem_wdata  = ((r_state == S_WR) && (r_op == OP_INSERT)) ? {1'b1, r_key, r_value}
                                                                  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LOOKUP;
            r_key       <= '0;
            r_adr       <= '0;
            r_value     <= '0;
            r_status    <= ST_OK;
            r_rsp_value <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op        <= req_op;
                        r_key       <= req_key;
                        r_adr       <= req_hash_adr;
                        r_value     <= req_value;
                        r_rsp_value <= '0;
                        if (req_op == OP_ILLEGAL) begin
                            r_status <= ST_ILLEGAL;
                            r_state  <= S_RSP;
                        end else begin
                            r_status <= ST_OK;
                            r_state  <= S_RD;
                        end
                    end
                end
                S_RD: r_state <= S_CMP;
                S_CMP: begin
                    case (r_op)
                        OP_LOOKUP: begin
                            r_status    <= w_hit ? ST_OK : ST_NFOUND;
                            r_rsp_value <= w_hit ? w_stored_value : '0;
                            r_state     <= S_RSP;
                        end
                        OP_INSERT: begin
                            if (!w_stored_valid || w_hit) begin
                                r_state <= S_WR;
                            end else begin
                                r_status <= ST_COLL;
                                r_state  <= S_RSP;
                            end
                        end
                        OP_DELETE: begin
                            if (w_hit) begin
                                r_state <= S_WR;
                            end else begin
                                r_status <= ST_NFOUND;
                                r_state  <= S_RSP;
                            end
                        end
                        default: r_state <= S_RSP;
                    endcase
                end
                S_WR: begin
                    r_status <= ST_OK;
                    r_state  <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef H3_TABLE_STATS_EN
    logic [15:0] r_stat_hits;
    logic [15:0] r_stat_misses;
    logic [15:0] r_stat_collisions;

    // Counted on the response handshake so each op is counted exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_hits       <= '0;
            r_stat_misses     <= '0;
            r_stat_collisions <= '0;
        end else if (w_rsp_done) begin
            if ((r_op == OP_LOOKUP) && (r_status == ST_OK) && (r_stat_hits != 16'hFFFF))
                r_stat_hits <= r_stat_hits + 16'd1;
            if ((r_status == ST_NFOUND) && (r_stat_misses != 16'hFFFF))
                r_stat_misses <= r_stat_misses + 16'd1;
            if ((r_status == ST_COLL) && (r_stat_collisions != 16'hFFFF))
                r_stat_collisions <= r_stat_collisions + 16'd1;
        end
    end

    assign stat_hits       = r_stat_hits;
    assign stat_misses     = r_stat_misses;
    assign stat_collisions = r_stat_collisions;
`else
    logic w_unused_rsp_done;
    assign w_unused_rsp_done = w_rsp_done;
`endif

endmodule
